mac_accum_pipe: RTL

- Parametrised successor to the fixed 9-lane multiplier/adder-tree/bias datapath.
- Each beat multiplies LANES signed operand pairs, sums them in a pipelined adder tree, adds the bias on the first beat of a group, and accumulates the group at full precision.
- At the last beat it emits one rounded, saturated OUT_W result over a valid/ready handshake.
- Sits between the PE operand feeder and the activation/output buffer.

---
 rtl/mac_pkg.sv | 33 +++
 rtl/mac_addertree_pipe.sv | 68 ++++++
 rtl/mac_accum_pipe.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared defaults, tree width helper and saturation limits for the MAC pipe
package mac_pkg;

  localparam int DEF_LANES     = 9;
  localparam int DEF_IN_W      = 8;
  localparam int DEF_BIAS_W    = 16;
  localparam int DEF_ACC_W     = 32;
  localparam int DEF_OUT_W     = 13;
  localparam int DEF_SHIFT     = 6;
  localparam int DEF_ROUND     = 0;
  localparam int DEF_TREE_PIPE = 2;

  localparam int LIM_W = 64;

  // Exact width of a sum of `lanes` signed products of two in_w-bit operands.
  function automatic int tree_sum_w(input int lanes, input int in_w);
    return 2 * in_w + $clog2(lanes);
  endfunction

  function automatic logic signed [LIM_W-1:0] sat_max(input int w);
    return signed'((64'd1 << (w - 1)) - 64'd1);
  endfunction

  function automatic logic signed [LIM_W-1:0] sat_min(input int w);
    return ~sat_max(w);
  endfunction

  localparam logic signed [LIM_W-1:0] DEF_ACC_MAX = sat_max(DEF_ACC_W);
  localparam logic signed [LIM_W-1:0] DEF_ACC_MIN = sat_min(DEF_ACC_W);
  localparam logic signed [LIM_W-1:0] DEF_OUT_MAX = sat_max(DEF_OUT_W);
  localparam logic signed [LIM_W-1:0] DEF_OUT_MIN = sat_min(DEF_OUT_W);

endpackage

// File: rtl/mac_addertree_pipe.sv
// rtl/mac_addertree_pipe.sv - pipelined signed binary adder tree with a shared stage enable
module mac_addertree_pipe
  import mac_pkg::*;
#(
  parameter int LANES     = DEF_LANES,
  parameter int W         = 2 * DEF_IN_W,
  parameter int TREE_PIPE = DEF_TREE_PIPE,
  localparam int SW       = W + $clog2(LANES)
) (
  input  logic                    clk,
  input  logic                    en,
  input  logic [LANES*W-1:0]      operands,
  output logic signed [SW-1:0]    sum
);

  localparam int LEVELS = (LANES > 1) ? $clog2(LANES) : 1;
  // One spare zero entry lets every level add pairs without an odd-lane guard.
  localparam int NE = LANES + 1;

  logic [NE*SW-1:0]    lvl [LEVELS+1];
  logic [LANES*SW-1:0] ext;

  always_comb begin
    ext = '0;
    for (int i = 0; i < LANES; i++) begin
      ext[i*SW +: SW] = SW'(signed'(operands[i*W +: W]));
    end
  end

  assign lvl[0] = {{SW{1'b0}}, ext};

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    // Registers are spread evenly over the levels; extra ones stack up where the division lands.
    localparam int NREG = ((l + 1) * TREE_PIPE) / LEVELS - (l * TREE_PIPE) / LEVELS;

    logic [NE*SW-1:0] sums;

    always_comb begin
      sums = '0;
      for (int i = 0; i < NE / 2; i++) begin
        sums[i*SW +: SW] = lvl[l][2*i*SW +: SW] + lvl[l][(2*i+1)*SW +: SW];
      end
    end

    if (NREG == 0) begin : g_comb
      assign lvl[l+1] = sums;
    end else begin : g_reg
      logic [NE*SW-1:0] pipe [NREG];

      always_ff @(posedge clk) begin
        if (en) begin
          pipe[0] <= sums;
          for (int k = 1; k < NREG; k++) begin
            pipe[k] <= pipe[k-1];
          end
        end
      end

      assign lvl[l+1] = pipe[NREG-1];
    end
  end

  logic unused_hi;
  assign unused_hi = ^lvl[LEVELS][NE*SW-1:SW];

  assign sum = signed'(lvl[LEVELS][SW-1:0]);

endmodule

// File: rtl/mac_accum_pipe.sv
// rtl/mac_accum_pipe.sv - LANES-wide signed MAC with pipelined tree, group accumulator and saturating output
module mac_accum_pipe
  import mac_pkg::*;
#(
  parameter int LANES     = DEF_LANES,
  parameter int IN_W      = DEF_IN_W,
  parameter int BIAS_W    = DEF_BIAS_W,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int OUT_W     = DEF_OUT_W,
  parameter int SHIFT     = DEF_SHIFT,
  parameter int ROUND     = DEF_ROUND,
  parameter int TREE_PIPE = DEF_TREE_PIPE
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_first,
  input  logic                    in_last,
  input  logic [LANES*IN_W-1:0]   multiplicand,
  input  logic [LANES*IN_W-1:0]   multiplier,
  input  logic [BIAS_W-1:0]       bias,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_data,
  output logic                    out_sat,
  output logic                    err_seq
);

  localparam int PW  = 2 * IN_W;
  localparam int SW  = tree_sum_w(LANES, IN_W);
  localparam int AW1 = ACC_W + 1;

  localparam logic signed [AW1-1:0] ACC_HI = AW1'(sat_max(ACC_W));
  localparam logic signed [AW1-1:0] ACC_LO = AW1'(sat_min(ACC_W));
  localparam logic signed [AW1-1:0] OUT_HI = AW1'(sat_max(OUT_W));
  localparam logic signed [AW1-1:0] OUT_LO = AW1'(sat_min(OUT_W));
  localparam logic signed [AW1-1:0] RND    =
    (ROUND != 0 && SHIFT > 0) ? (AW1'(1) << (SHIFT > 0 ? SHIFT - 1 : 0)) : '0;

  logic en;
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  // Operand capture stage
  logic                  i_valid, i_first, i_last;
  logic [BIAS_W-1:0]     i_bias;
  logic [LANES*IN_W-1:0] i_mcand, i_mplier;

  always_ff @(posedge clk) begin
    if (reset) begin
      i_valid <= 1'b0;
    end else if (en) begin
      i_valid  <= in_valid;
      i_first  <= in_first;
      i_last   <= in_last;
      i_bias   <= in_first ? bias : '0;
      i_mcand  <= multiplicand;
      i_mplier <= multiplier;
    end
  end

  logic [LANES*PW-1:0] prod;

  always_comb begin
    prod = '0;
    for (int i = 0; i < LANES; i++) begin
      prod[i*PW +: PW] = PW'(signed'(i_mcand[i*IN_W +: IN_W])) *
                         PW'(signed'(i_mplier[i*IN_W +: IN_W]));
    end
  end

  // Product stage
  logic                s0_valid, s0_first, s0_last;
  logic [BIAS_W-1:0]   s0_bias;
  logic [LANES*PW-1:0] s0_prod;

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_valid <= 1'b0;
    end else if (en) begin
      s0_valid <= i_valid;
      s0_first <= i_first;
      s0_last  <= i_last;
      s0_bias  <= i_bias;
      s0_prod  <= prod;
    end
  end

  logic signed [SW-1:0] tree_sum;

  mac_addertree_pipe #(
    .LANES     (LANES),
    .W         (PW),
    .TREE_PIPE (TREE_PIPE)
  ) u_tree (
    .clk      (clk),
    .en       (en),
    .operands (s0_prod),
    .sum      (tree_sum)
  );

  // Control rides alongside the tree registers
  logic [TREE_PIPE-1:0] t_valid, t_first, t_last;
  logic [BIAS_W-1:0]    t_bias [TREE_PIPE];

  always_ff @(posedge clk) begin
    if (reset) begin
      t_valid <= '0;
    end else if (en) begin
      t_valid[0] <= s0_valid;
      t_first[0] <= s0_first;
      t_last[0]  <= s0_last;
      t_bias[0]  <= s0_bias;
      for (int k = 1; k < TREE_PIPE; k++) begin
        t_valid[k] <= t_valid[k-1];
        t_first[k] <= t_first[k-1];
        t_last[k]  <= t_last[k-1];
        t_bias[k]  <= t_bias[k-1];
      end
    end
  end

  logic              a_valid, a_first, a_last;
  logic [BIAS_W-1:0] a_bias;

  assign a_valid = t_valid[TREE_PIPE-1];
  assign a_first = t_first[TREE_PIPE-1];
  assign a_last  = t_last[TREE_PIPE-1];
  assign a_bias  = t_bias[TREE_PIPE-1];

  logic signed [ACC_W-1:0] acc;
  logic                    open, sticky;

  logic                  eff_first, frame_err, acc_ovf, sticky_next, clip;
  logic signed [AW1-1:0] base, acc_sum, acc_sat, rnd_sum, shifted;
  logic [OUT_W-1:0]      out_next;

  always_comb begin
    // A beat without an open group starts one; the bias register is already zero then.
    eff_first   = a_first | ~open;
    frame_err   = a_first ? open : ~open;
    base        = eff_first ? AW1'(signed'(a_bias)) : AW1'(acc);
    acc_sum     = base + AW1'(tree_sum);
    acc_sat     = acc_sum;
    acc_ovf     = 1'b0;
    if (acc_sum > ACC_HI) begin
      acc_sat = ACC_HI;
      acc_ovf = 1'b1;
    end else if (acc_sum < ACC_LO) begin
      acc_sat = ACC_LO;
      acc_ovf = 1'b1;
    end
    sticky_next = (eff_first ? 1'b0 : sticky) | acc_ovf;

    rnd_sum  = acc_sat + RND;
    shifted  = rnd_sum >>> SHIFT;
    clip     = 1'b1;
    out_next = OUT_W'(shifted);
    if (shifted > OUT_HI) begin
      out_next = OUT_W'(OUT_HI);
    end else if (shifted < OUT_LO) begin
      out_next = OUT_W'(OUT_LO);
    end else begin
      clip = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      open      <= 1'b0;
      sticky    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      err_seq   <= 1'b0;
    end else if (en) begin
      err_seq   <= a_valid & frame_err;
      out_valid <= a_valid & a_last;
      if (a_valid) begin
        acc    <= ACC_W'(acc_sat);
        open   <= ~a_last;
        sticky <= a_last ? 1'b0 : sticky_next;
        if (a_last) begin
          out_data <= out_next;
          out_sat  <= clip | sticky_next;
        end
      end
    end else begin
      err_seq <= 1'b0;
    end
  end

endmodule
